// File: rtl/mem_arbiter_if.sv
// +--------------------------------------------------------------------------+
// | mem_arbiter_if : CPU / debug requester ports and single-port memory bus  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

interface mem_arbiter_if #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [AWIDTH-1:0] cpu_addr;
  logic [DWIDTH-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_done;
  logic [DWIDTH-1:0] cpu_rdata;

  logic              dbg_req;
  logic              dbg_we;
  logic [AWIDTH-1:0] dbg_addr;
  logic [DWIDTH-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_done;
  logic [DWIDTH-1:0] dbg_rdata;

  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [DWIDTH-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_done, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_done, dbg_rdata,
    output mem_addr, mem_wdata, mem_rd, mem_wr,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_done, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_done, dbg_rdata,
    input  mem_addr, mem_wdata, mem_rd, mem_wr,
    output mem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// +--------------------------------------------------------------------------+
// | mem_arbiter : round-robin CPU/debug arbiter for a single-port memory     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module mem_arbiter #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  localparam logic c_cpu = 1'b0;
  localparam logic c_dbg = 1'b1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_owner;
  logic              r_last_owner;
  logic              r_we;
  logic [AWIDTH-1:0] r_addr;
  logic [DWIDTH-1:0] r_wdata;
  logic [DWIDTH-1:0] r_cpu_rdata;
  logic [DWIDTH-1:0] r_dbg_rdata;
  logic              w_any_req;
  logic              w_winner;

  assign w_any_req = bus.cpu_req | bus.dbg_req;
  // On contention the requester that did not go last wins.
  assign w_winner  = (bus.cpu_req && bus.dbg_req) ? ~r_last_owner : bus.dbg_req;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_owner      <= c_cpu;
      r_last_owner <= c_dbg;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cpu_rdata  <= '0;
      r_dbg_rdata  <= '0;
    end else begin
      if (r_state == IDLE && w_any_req) begin
        r_owner <= w_winner;
        r_we    <= (w_winner == c_dbg) ? bus.dbg_we    : bus.cpu_we;
        r_addr  <= (w_winner == c_dbg) ? bus.dbg_addr  : bus.cpu_addr;
        r_wdata <= (w_winner == c_dbg) ? bus.dbg_wdata : bus.cpu_wdata;
      end
      if (r_state == ACCESS) begin
        r_last_owner <= r_owner;
        if (!r_we) begin
          if (r_owner == c_dbg) begin
            r_dbg_rdata <= bus.mem_rdata;
          end else begin
            r_cpu_rdata <= bus.mem_rdata;
          end
        end
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    bus.cpu_gnt   = 1'b0;
    bus.cpu_done  = 1'b0;
    bus.dbg_gnt   = 1'b0;
    bus.dbg_done  = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        w_state_nxt   = COMPLETE;
        bus.cpu_gnt   = (r_owner == c_cpu);
        bus.dbg_gnt   = (r_owner == c_dbg);
        bus.mem_addr  = r_addr;
        bus.mem_wdata = r_wdata;
        bus.mem_rd    = ~r_we;
        bus.mem_wr    = r_we;
      end
      COMPLETE: begin
        w_state_nxt  = IDLE;
        bus.cpu_gnt  = (r_owner == c_cpu);
        bus.dbg_gnt  = (r_owner == c_dbg);
        bus.cpu_done = (r_owner == c_cpu);
        bus.dbg_done = (r_owner == c_dbg);
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.dbg_rdata = r_dbg_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_mem_arbiter : directed and random checks against a transaction model  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mem_arbiter;

  localparam int AW = 5;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_ = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  logic [DW-1:0] mem_arr [32];
  assign bus.mem_rdata = bus.mem_rd ? mem_arr[bus.mem_addr] : 8'hEE;

  int checks = 0;
  int errors = 0;

  // Reference model: an access granted at edge g occupies edges g..g+2,
  // so the next arbitration can happen at edge g+3 at the earliest.
  logic [DW-1:0] ref_mem [32];
  logic [DW-1:0] m_rd [2];
  int            e_cnt = 0;
  int            g = -100;
  int            m_owner = 0;
  int            m_last = 1;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;

  int own_q[$];
  int t_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    g       = -100;
    m_owner = 0;
    m_last  = 1;
    m_rd[0] = '0;
    m_rd[1] = '0;
  endtask

  task automatic model_edge();
    int p;
    p = e_cnt - g;
    if (p == 1) begin
      if (m_we) ref_mem[m_addr] = m_wdata;
      else      m_rd[m_owner]   = ref_mem[m_addr];
      m_last = m_owner;
    end
    if (p >= 3 && (bus.cpu_req || bus.dbg_req)) begin
      if (bus.cpu_req && bus.dbg_req) m_owner = (m_last == 0) ? 1 : 0;
      else                            m_owner = bus.dbg_req ? 1 : 0;
      m_we    = (m_owner == 1) ? bus.dbg_we    : bus.cpu_we;
      m_addr  = (m_owner == 1) ? bus.dbg_addr  : bus.cpu_addr;
      m_wdata = (m_owner == 1) ? bus.dbg_wdata : bus.cpu_wdata;
      g = e_cnt;
    end
    e_cnt++;
  endtask

  task automatic check_all();
    int p;
    bit acc, cmp;
    p   = (e_cnt - 1) - g;
    acc = (p == 0);
    cmp = (p == 1);
    chk("cpu_gnt",   32'(bus.cpu_gnt),   32'((acc || cmp) && m_owner == 0));
    chk("dbg_gnt",   32'(bus.dbg_gnt),   32'((acc || cmp) && m_owner == 1));
    chk("cpu_done",  32'(bus.cpu_done),  32'(cmp && m_owner == 0));
    chk("dbg_done",  32'(bus.dbg_done),  32'(cmp && m_owner == 1));
    chk("mem_rd",    32'(bus.mem_rd),    32'(acc && !m_we));
    chk("mem_wr",    32'(bus.mem_wr),    32'(acc && m_we));
    chk("mem_addr",  32'(bus.mem_addr),  acc ? 32'(m_addr)  : 32'd0);
    chk("mem_wdata", 32'(bus.mem_wdata), acc ? 32'(m_wdata) : 32'd0);
    chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(m_rd[0]));
    chk("dbg_rdata", 32'(bus.dbg_rdata), 32'(m_rd[1]));
  endtask

  // Called at a negedge with inputs already applied; returns at the next negedge.
  task automatic tick();
    if (bus.mem_wr) mem_arr[bus.mem_addr] = bus.mem_wdata;
    if (rst_) model_edge();
    else      e_cnt++;
    @(negedge clk);
    check_all();
  endtask

  task automatic drain();
    bus.cpu_req = 1'b0;
    bus.dbg_req = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
    for (int i = 0; i < 32; i++) begin
      mem_arr[i] = 8'($urandom);
      ref_mem[i] = mem_arr[i];
    end
    model_reset();

    @(negedge clk);
    check_all();
    @(negedge clk);
    rst_ = 1'b1;

    // CPU read of 0x0A returning 0x3C
    mem_arr[10] = 8'h3C;
    ref_mem[10] = 8'h3C;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 5'h0A;
    tick();
    chk("r034_mem_rd",   32'(bus.mem_rd),   32'd1);
    chk("r034_mem_addr", 32'(bus.mem_addr), 32'h0A);
    tick();
    chk("r034_done",  32'(bus.cpu_done),  32'd1);
    chk("r034_rdata", 32'(bus.cpu_rdata), 32'h3C);
    bus.cpu_req = 0;
    tick();

    // DBG write of 0xA5 to 0x1F
    bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_addr = 5'h1F; bus.dbg_wdata = 8'hA5;
    tick();
    chk("r035_mem_wr",    32'(bus.mem_wr),    32'd1);
    chk("r035_mem_addr",  32'(bus.mem_addr),  32'h1F);
    chk("r035_mem_wdata", 32'(bus.mem_wdata), 32'hA5);
    tick();
    chk("r035_done",      32'(bus.dbg_done),  32'd1);
    chk("r035_wr_once",   32'(bus.mem_wr),    32'd0);
    chk("r035_cpu_rdata", 32'(bus.cpu_rdata), 32'h3C);
    bus.dbg_req = 0;
    tick();
    chk("r035_mem_content", 32'(mem_arr[31]), 32'hA5);

    // Both requesting continuously straight after reset
    rst_ = 1'b0;
    model_reset();
    tick();
    rst_ = 1'b1;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 5'h02;
    bus.dbg_req = 1; bus.dbg_we = 0; bus.dbg_addr = 5'h04;
    own_q.delete();
    t_q.delete();
    repeat (12) begin
      tick();
      if (bus.mem_rd || bus.mem_wr) begin
        own_q.push_back(bus.dbg_gnt ? 1 : 0);
        t_q.push_back(e_cnt);
      end
    end
    chk("r036_count", 32'(own_q.size()), 32'd4);
    if (own_q.size() >= 4) begin
      chk("r036_g0", 32'(own_q[0]), 32'd0);
      chk("r036_g1", 32'(own_q[1]), 32'd1);
      chk("r036_g2", 32'(own_q[2]), 32'd0);
      chk("r036_g3", 32'(own_q[3]), 32'd1);
      chk("r036_spacing", 32'(t_q[3] - t_q[2]), 32'd3);
    end
    drain();

    // Requester input change during ACCESS is ignored
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 5'h03;
    tick();
    bus.cpu_addr = 5'h07;
    #1;
    chk("r037_mem_addr", 32'(bus.mem_addr), 32'h03);
    tick();
    drain();

    // Reset in the middle of a DBG write
    bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_addr = 5'h11; bus.dbg_wdata = 8'h77;
    tick();
    chk("r038_wr_before", 32'(bus.mem_wr), 32'd1);
    rst_ = 1'b0;
    #1;
    chk("r038_wr_drop",  32'(bus.mem_wr),  32'd0);
    chk("r038_gnt_drop", 32'(bus.dbg_gnt), 32'd0);
    model_reset();
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 5'h05;
    tick();
    chk("r038_no_done", 32'(bus.dbg_done), 32'd0);
    rst_ = 1'b1;
    tick();
    chk("r038_cpu_first", 32'(bus.cpu_gnt), 32'd1);
    drain();

    // DBG request raised in the CPU done cycle waits for the next IDLE sample
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 5'h08;
    tick();
    tick();
    chk("r039_cpu_done", 32'(bus.cpu_done), 32'd1);
    bus.cpu_req = 0;
    bus.dbg_req = 1; bus.dbg_we = 0; bus.dbg_addr = 5'h09;
    tick();
    chk("r039_held_off", 32'(bus.dbg_gnt), 32'd0);
    tick();
    chk("r039_dbg_gnt", 32'(bus.dbg_gnt), 32'd1);
    chk("r039_dbg_rd",  32'(bus.mem_rd),  32'd1);
    drain();

    // Random traffic with occasional resets
    repeat (400) begin
      bus.cpu_req   = ($urandom_range(0, 3) != 0);
      bus.cpu_we    = 1'($urandom);
      bus.cpu_addr  = 5'($urandom);
      bus.cpu_wdata = 8'($urandom);
      bus.dbg_req   = ($urandom_range(0, 2) != 0);
      bus.dbg_we    = 1'($urandom);
      bus.dbg_addr  = 5'($urandom);
      bus.dbg_wdata = 8'($urandom);
      if ($urandom_range(0, 59) == 0) begin
        rst_ = 1'b0;
        model_reset();
        tick();
        rst_ = 1'b1;
      end else begin
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AWIDTH, default 5, memory address width.
REQ-002 Parameter DWIDTH, default 8, memory data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_  input  1  asynchronous, active-low reset.
REQ-005 cpu_req  input  1  CPU memory access request; held until cpu_done.
REQ-006 cpu_we  input  1  CPU access type: 1 = write, 0 = read.
REQ-007 cpu_addr  input  AWIDTH  CPU access address.
REQ-008 cpu_wdata  input  DWIDTH  CPU write data.
REQ-009 cpu_gnt  output  1  CPU currently owns memory.
REQ-010 cpu_done  output  1  one-cycle CPU completion pulse.
REQ-011 cpu_rdata  output  DWIDTH  CPU read result, valid while cpu_done=1.
REQ-012 dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_done, dbg_rdata  same directions/widths/meanings as the CPU set, for the debug loader.
REQ-013 mem_addr  output  AWIDTH  address to single-port memory.
REQ-014 mem_wdata  output  DWIDTH  write data to memory.
REQ-015 mem_rd  output  1  memory read strobe.
REQ-016 mem_wr  output  1  memory write strobe.
REQ-017 mem_rdata  input  DWIDTH  memory read data, combinationally valid in the cycle mem_rd=1.

Function
REQ-018 FSM states SHALL be IDLE, ACCESS, COMPLETE; an owner register (CPU/DBG) and a last_owner register SHALL be kept.
REQ-019 IDLE: no request -> stay IDLE; any request -> ACCESS next edge, owner chosen per REQ-020.
REQ-020 Arbitration SHALL be round-robin: single requester wins; both requesting -> requester that is not last_owner wins.
REQ-021 On the IDLE->ACCESS edge the winner's we/addr/wdata SHALL be latched; later changes to requester inputs SHALL NOT affect the access.
REQ-022 ACCESS (exactly 1 cycle): owner gnt=1; mem_addr/mem_wdata from latched values; mem_rd=~we, mem_wr=we; next state COMPLETE.
REQ-023 At the ACCESS->COMPLETE edge, for a read, mem_rdata SHALL be captured into the owner's rdata register; last_owner SHALL be updated to owner.
REQ-024 COMPLETE (exactly 1 cycle): owner gnt=1 and done=1; mem_rd=mem_wr=0; next state IDLE unconditionally.
REQ-025 Latency SHALL be fixed: request sampled in IDLE at edge N -> strobe in cycle N+1 -> done in cycle N+2; minimum spacing between accesses 3 cycles.
REQ-026 Requester SHALL drop req in its done cycle; req still high in the following IDLE is a new request.
REQ-027 Non-owner gnt and done SHALL be 0 at all times; gnt SHALL be 1 in both ACCESS and COMPLETE for the owner only.
REQ-028 mem_rd and mem_wr SHALL never be 1 simultaneously and SHALL be 0 outside ACCESS; mem_addr/mem_wdata SHALL be 0 outside ACCESS.
REQ-029 rdata registers SHALL hold their value until the next read by the same requester; write accesses SHALL NOT modify them.
REQ-030 Requests arriving during ACCESS/COMPLETE SHALL be held off (no grant) and evaluated in the next IDLE.

Reset
REQ-031 rst_=0 SHALL immediately force state IDLE, owner=CPU, last_owner=DBG, both rdata registers to 0, and all outputs to 0.
REQ-032 Reset during ACCESS SHALL abort the access with no done pulse; mem_rd/mem_wr drop asynchronously.
REQ-033 First contended arbitration after reset SHALL grant CPU.

Verification
REQ-034 CPU read, addr=5'h0A, mem returns 8'h3C -> mem_rd=1, mem_addr=0x0A in cycle N+1; cpu_done=1, cpu_rdata=0x3C in N+2; dbg outputs 0 throughout.
REQ-035 DBG write addr=5'h1F, wdata=8'hA5 -> mem_wr=1, mem_addr=0x1F, mem_wdata=0xA5 for exactly one cycle; dbg_done next cycle; cpu_rdata unchanged.
REQ-036 Both req held continuously after reset -> grant order CPU, DBG, CPU, DBG, one access per 3 cycles.
REQ-037 cpu_addr changed 0x03->0x07 during ACCESS -> mem_addr stays 0x03.
REQ-038 rst_ pulsed low during DBG ACCESS -> mem_wr/dbg_gnt drop immediately, no dbg_done; after release with both req high, CPU granted first.
REQ-039 DBG requests during a CPU COMPLETE cycle -> dbg_gnt stays 0 until the IDLE sample; DBG ACCESS starts 2 cycles after CPU done.
